issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 47 ++++
 rtl/issue_ctrl_if.sv | 61 ++++++
 rtl/issue_ctrl_reg_status.sv | 57 +++++
 rtl/issue_ctrl.sv | 118 +++++++++++
 tb/tb_issue_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared types, sizes and tag helpers for the issue controller
// Contents: unit_t, ldst_mode_t, bool, N_UNIT/N_SLOT/TAG_W defaults,
// tag_encode/tag_unit/tag_slot. Tag 0 means "value ready"; a nonzero tag
// names one reservation-station slot as unit_index*N_SLOT + slot + 1.
package issue_ctrl_pkg;

    typedef logic bool;

    typedef enum logic [2:0] {
        UNIT_ALU    = 3'd0,
        UNIT_MUL    = 3'd1,
        UNIT_DIV    = 3'd2,
        UNIT_BRANCH = 3'd3,
        UNIT_LOAD   = 3'd4,
        UNIT_STORE  = 3'd5
    } unit_t;

    typedef enum logic [2:0] {
        LDST_NONE = 3'd0,
        LDST_B    = 3'd1,
        LDST_H    = 3'd2,
        LDST_W    = 3'd3,
        LDST_BU   = 3'd4,
        LDST_HU   = 3'd5
    } ldst_mode_t;

    localparam int N_UNIT = 6;
    localparam int N_SLOT = 2;
    localparam int TAG_W  = 4;

    function automatic int unsigned tag_encode(input int unsigned unit_idx,
                                               input int unsigned slot,
                                               input int unsigned n_slot);
        return unit_idx * n_slot + slot + 1;
    endfunction

    function automatic int unsigned tag_unit(input int unsigned tag,
                                             input int unsigned n_slot);
        return (tag - 1) / n_slot;
    endfunction

    function automatic int unsigned tag_slot(input int unsigned tag,
                                             input int unsigned n_slot);
        return (tag - 1) % n_slot;
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - decoder / register-file / CDB / reservation-station bundle
// master: decoder-side driver (instruction in, RF data, CDB, releases, flush).
// slave : issue_ctrl (in_ready, RF read addresses, reservation-station write).
interface issue_ctrl_if import issue_ctrl_pkg::*; #(
    parameter int N_SLOT = issue_ctrl_pkg::N_SLOT,
    parameter int TAG_W  = issue_ctrl_pkg::TAG_W
) ();
    // decoded instruction
    logic              in_valid;
    logic              in_ready;
    unit_t             in_unit;
    logic [9:0]        in_op;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rd;
    logic [31:0]       in_vj;
    logic [31:0]       in_vk;
    logic [31:0]       in_a;
    bool               in_a_rdy;
    ldst_mode_t        in_rwmm;
    // register file read, same cycle
    logic [4:0]        rf_raddr_j;
    logic [4:0]        rf_raddr_k;
    logic [31:0]       rf_rdata_j;
    logic [31:0]       rf_rdata_k;
    // common data bus, slot release, flush
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_value;
    logic [6*N_SLOT-1:0] rs_release;
    logic              flush;
    // reservation-station write
    logic              rs_we;
    logic [TAG_W-1:0]  rs_tag;
    logic [9:0]        rs_op;
    ldst_mode_t        rs_rwmm;
    logic [31:0]       rs_a;
    bool               rs_a_rdy;
    logic [TAG_W-1:0]  rs_qj;
    logic [TAG_W-1:0]  rs_qk;
    logic [31:0]       rs_vj;
    logic [31:0]       rs_vk;

    modport master (
        output in_valid, in_unit, in_op, in_rs1, in_rs2, in_rd,
               in_vj, in_vk, in_a, in_a_rdy, in_rwmm,
               rf_rdata_j, rf_rdata_k, cdb_valid, cdb_tag, cdb_value,
               rs_release, flush,
        input  in_ready, rf_raddr_j, rf_raddr_k, rs_we, rs_tag, rs_op,
               rs_rwmm, rs_a, rs_a_rdy, rs_qj, rs_qk, rs_vj, rs_vk
    );

    modport slave (
        input  in_valid, in_unit, in_op, in_rs1, in_rs2, in_rd,
               in_vj, in_vk, in_a, in_a_rdy, in_rwmm,
               rf_rdata_j, rf_rdata_k, cdb_valid, cdb_tag, cdb_value,
               rs_release, flush,
        output in_ready, rf_raddr_j, rf_raddr_k, rs_we, rs_tag, rs_op,
               rs_rwmm, rs_a, rs_a_rdy, rs_qj, rs_qk, rs_vj, rs_vk
    );
endinterface

// File: rtl/issue_ctrl_reg_status.sv
// rtl/issue_ctrl_reg_status.sv - 32-entry register status table (producer tag per register)
// Ports: clk, rst_n (async, active low), flush, we/waddr/wtag (issue write),
// cdb_valid/cdb_tag (broadcast clear), raddr_j/raddr_k -> rtag_j/rtag_k
// (combinational reads of the registered table).
module reg_status #(
    parameter int TAG_W = issue_ctrl_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [TAG_W-1:0] wtag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [4:0]       raddr_j,
    input  logic [4:0]       raddr_k,
    output logic [TAG_W-1:0] rtag_j,
    output logic [TAG_W-1:0] rtag_k
);
    logic [TAG_W-1:0] status_q [32];
    logic [TAG_W-1:0] status_d [32];

    // Later assignments win: a same-cycle issue write beats the CDB clear,
    // flush beats everything, and x0 is never marked busy.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            status_d[i] = status_q[i];
            if (cdb_valid && (status_q[i] == cdb_tag)) begin
                status_d[i] = '0;
            end
            if (we && (waddr == 5'(i))) begin
                status_d[i] = wtag;
            end
            if (flush) begin
                status_d[i] = '0;
            end
        end
        status_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                status_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                status_q[i] <= status_d[i];
            end
        end
    end

    assign rtag_j = status_q[raddr_j];
    assign rtag_k = status_q[raddr_k];

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - Tomasulo-style issue stage: slot allocation, operand/tag resolution
// Ports: clk, rst_n (async, active low), bus (issue_ctrl_if.slave): decoded
// instruction in with in_ready, RF read addresses/data, CDB, rs_release,
// flush, and the zero-latency reservation-station write (rs_we/rs_tag/...).
module issue_ctrl import issue_ctrl_pkg::*; #(
    parameter int N_SLOT = issue_ctrl_pkg::N_SLOT,
    parameter int TAG_W  = issue_ctrl_pkg::TAG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    issue_ctrl_if.slave  bus
);
    localparam int N_ENT = N_UNIT * N_SLOT;

    logic [N_ENT-1:0] busy_q;
    logic [N_ENT-1:0] busy_d;
    logic [N_ENT-1:0] alloc_onehot;
    logic             slot_found;
    logic [TAG_W-1:0] alloc_tag;
    logic [TAG_W-1:0] stat_j;
    logic [TAG_W-1:0] stat_k;
    int unsigned      unit_idx;

    assign unit_idx = int'(bus.in_unit);

    // Lowest free slot of the requested unit, from the registered bitmap only,
    // so a slot released this cycle stays unavailable until the next one.
    always_comb begin
        slot_found   = 1'b0;
        alloc_onehot = '0;
        alloc_tag    = '0;
        if (unit_idx < N_UNIT) begin
            for (int s = 0; s < N_SLOT; s++) begin
                if (!slot_found && !busy_q[unit_idx * N_SLOT + s]) begin
                    slot_found = 1'b1;
                    alloc_onehot[unit_idx * N_SLOT + s] = 1'b1;
                    alloc_tag = TAG_W'(tag_encode(unit_idx, int'(s), N_SLOT));
                end
            end
        end
    end

    assign bus.in_ready = rst_n && !bus.flush && slot_found;
    assign bus.rs_we    = bus.in_valid && bus.in_ready;
    assign bus.rs_tag   = alloc_tag;

    assign bus.rs_op    = bus.in_op;
    assign bus.rs_rwmm  = bus.in_rwmm;
    assign bus.rs_a     = bus.in_a;
    assign bus.rs_a_rdy = bus.in_a_rdy;

    assign bus.rf_raddr_j = bus.in_rs1;
    assign bus.rf_raddr_k = bus.in_rs2;

    // Release clears only what is set, so releasing a free slot is a no-op;
    // a new allocation is OR'd in afterwards.
    always_comb begin
        busy_d = (busy_q & ~bus.rs_release) | (bus.rs_we ? alloc_onehot : '0);
        if (bus.flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    reg_status #(.TAG_W(TAG_W)) u_reg_status (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .we        (bus.rs_we),
        .waddr     (bus.in_rd),
        .wtag      (alloc_tag),
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .raddr_j   (bus.in_rs1),
        .raddr_k   (bus.in_rs2),
        .rtag_j    (stat_j),
        .rtag_k    (stat_k)
    );

    // Operand resolution order: x0 uses the decoder value, an idle register
    // reads the RF, a producer broadcasting right now is bypassed from the
    // CDB, otherwise the operand waits on the producer tag.
    always_comb begin
        bus.rs_qj = '0;
        bus.rs_vj = '0;
        if (bus.in_rs1 == 5'd0) begin
            bus.rs_vj = bus.in_vj;
        end else if (stat_j == '0) begin
            bus.rs_vj = bus.rf_rdata_j;
        end else if (bus.cdb_valid && (stat_j == bus.cdb_tag)) begin
            bus.rs_vj = bus.cdb_value;
        end else begin
            bus.rs_qj = stat_j;
        end
    end

    always_comb begin
        bus.rs_qk = '0;
        bus.rs_vk = '0;
        if (bus.in_rs2 == 5'd0) begin
            bus.rs_vk = bus.in_vk;
        end else if (stat_k == '0) begin
            bus.rs_vk = bus.rf_rdata_k;
        end else if (bus.cdb_valid && (stat_k == bus.cdb_tag)) begin
            bus.rs_vk = bus.cdb_value;
        end else begin
            bus.rs_qk = stat_k;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    logic [31:0] rf [32];
    int n_tests;
    int n_fail;

    issue_ctrl_if #(.N_SLOT(2), .TAG_W(4)) bus ();

    issue_ctrl #(.N_SLOT(2), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.rf_rdata_j = rf[bus.rf_raddr_j];
    assign bus.rf_rdata_k = rf[bus.rf_raddr_k];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        bus.in_valid   = 1'b0;
        bus.in_unit    = UNIT_ALU;
        bus.in_op      = 10'h0;
        bus.in_rs1     = 5'd0;
        bus.in_rs2     = 5'd0;
        bus.in_rd      = 5'd0;
        bus.in_vj      = 32'h0;
        bus.in_vk      = 32'h0;
        bus.in_a       = 32'h0;
        bus.in_a_rdy   = 1'b0;
        bus.in_rwmm    = LDST_NONE;
        bus.cdb_valid  = 1'b0;
        bus.cdb_tag    = 4'd0;
        bus.cdb_value  = 32'h0;
        bus.rs_release = 12'h0;
        bus.flush      = 1'b0;
    endtask

    task automatic issue(input unit_t u, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.in_unit  = u;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        set_idle();
        rst_n = 1'b0;

        // reset state
        issue(UNIT_ALU, 5'd1, 5'd2, 5'd3);
        #2;
        check("rst_we", bus.rs_we, 0);
        check("rst_ready", bus.in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        set_idle();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", bus.in_ready, 1);

        // ADD x3,x1,x2
        @(negedge clk);
        issue(UNIT_ALU, 5'd1, 5'd2, 5'd3);
        bus.in_op = 10'h033; bus.in_a = 32'h1000; bus.in_a_rdy = 1'b1; bus.in_rwmm = LDST_W;
        #1;
        check("add1_we", bus.rs_we, 1);
        check("add1_tag", bus.rs_tag, 1);
        check("add1_qj", bus.rs_qj, 0);
        check("add1_qk", bus.rs_qk, 0);
        check("add1_vj", bus.rs_vj, 5);
        check("add1_vk", bus.rs_vk, 7);
        check("add1_op", bus.rs_op, 10'h033);
        check("add1_a", bus.rs_a, 32'h1000);
        check("add1_rwmm", bus.rs_rwmm, LDST_W);

        // status[3] = tag 1, then ADD x4,x3,x3 with same-cycle CDB bypass
        @(negedge clk);
        set_idle();
        bus.in_rs1 = 5'd3;
        #1;
        check("stat3_busy", bus.rs_qj, 1);
        issue(UNIT_ALU, 5'd3, 5'd3, 5'd4);
        #1;
        check("add2_qj_wait", bus.rs_qj, 1);
        check("add2_qk_wait", bus.rs_qk, 1);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd1; bus.cdb_value = 32'd12;
        #1;
        check("add2_tag", bus.rs_tag, 2);
        check("add2_qj", bus.rs_qj, 0);
        check("add2_qk", bus.rs_qk, 0);
        check("add2_vj", bus.rs_vj, 12);
        check("add2_vk", bus.rs_vk, 12);

        @(negedge clk);
        set_idle();
        bus.in_rs1 = 5'd3; bus.in_rs2 = 5'd4;
        #1;
        check("stat3_cleared_qj", bus.rs_qj, 0);
        check("stat3_cleared_vj", bus.rs_vj, 32'h103);
        check("stat4_qk", bus.rs_qk, 2);
        check("alu_full_ready", bus.in_ready, 0);

        // MUL slots exhaust, release tag 3, third MUL issues next cycle
        @(negedge clk);
        set_idle();
        issue(UNIT_MUL, 5'd0, 5'd0, 5'd7);
        #1;
        check("mul1_tag", bus.rs_tag, 3);
        @(negedge clk);
        issue(UNIT_MUL, 5'd0, 5'd0, 5'd8);
        #1;
        check("mul2_tag", bus.rs_tag, 4);
        @(negedge clk);
        issue(UNIT_MUL, 5'd0, 5'd0, 5'd9);
        bus.rs_release = 12'h004;
        #1;
        check("mul3_blocked_ready", bus.in_ready, 0);
        check("mul3_blocked_we", bus.rs_we, 0);
        @(negedge clk);
        bus.rs_release = 12'h000;
        #1;
        check("mul3_ready", bus.in_ready, 1);
        check("mul3_tag", bus.rs_tag, 3);

        // free tag 1, reuse it for x10, then allocate+release in one cycle
        @(negedge clk);
        set_idle();
        bus.rs_release = 12'h001;
        @(negedge clk);
        set_idle();
        issue(UNIT_ALU, 5'd0, 5'd0, 5'd10);
        bus.rs_release = 12'h002;
        #1;
        check("x10_tag", bus.rs_tag, 1);
        @(negedge clk);
        set_idle();
        #1;
        check("alloc_rel_ready", bus.in_ready, 1);
        check("alloc_rel_tag", bus.rs_tag, 2);
        bus.rs_release = 12'h001;
        @(negedge clk);
        set_idle();
        // x5 gets tag 1 while the CDB broadcasts tag 1: new tag wins on x5, x10 clears
        issue(UNIT_ALU, 5'd0, 5'd0, 5'd5);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd1; bus.cdb_value = 32'h55;
        #1;
        check("x5_tag", bus.rs_tag, 1);
        @(negedge clk);
        set_idle();
        bus.in_rs1 = 5'd5; bus.in_rs2 = 5'd10;
        #1;
        check("stat5_kept", bus.rs_qj, 1);
        check("stat10_cleared", bus.rs_qk, 0);
        check("stat10_vk", bus.rs_vk, 32'h10a);

        // release bit for a free DIV slot is ignored; the allocation sticks
        @(negedge clk);
        set_idle();
        issue(UNIT_DIV, 5'd0, 5'd0, 5'd0);
        bus.rs_release = 12'h010;
        #1;
        check("div1_tag", bus.rs_tag, 5);
        @(negedge clk);
        set_idle();
        issue(UNIT_DIV, 5'd0, 5'd0, 5'd0);
        #1;
        check("div2_tag", bus.rs_tag, 6);

        // flush
        @(negedge clk);
        set_idle();
        issue(UNIT_ALU, 5'd1, 5'd2, 5'd11);
        bus.flush = 1'b1;
        #1;
        check("flush_ready", bus.in_ready, 0);
        check("flush_we", bus.rs_we, 0);
        @(negedge clk);
        set_idle();
        bus.in_unit = UNIT_MUL; bus.in_rs1 = 5'd5;
        #1;
        check("flush_stat5", bus.rs_qj, 0);
        check("flush_mul_tag", bus.rs_tag, 3);
        issue(UNIT_ALU, 5'd3, 5'd0, 5'd6);
        bus.in_vk = 32'hab;
        #1;
        check("add6_we", bus.rs_we, 1);
        check("add6_tag", bus.rs_tag, 1);
        check("add6_qj", bus.rs_qj, 0);
        check("add6_vj", bus.rs_vj, 32'h103);
        check("add6_vk", bus.rs_vk, 32'hab);

        // asynchronous reset between edges
        @(negedge clk);
        set_idle();
        issue(UNIT_ALU, 5'd6, 5'd0, 5'd7);
        #1;
        check("pre_rst_qj", bus.rs_qj, 1);
        check("pre_rst_tag", bus.rs_tag, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_we", bus.rs_we, 0);
        check("async_rst_qj", bus.rs_qj, 0);
        check("async_rst_vj", bus.rs_vj, 32'h106);
        rst_n = 1'b1;
        #1;
        check("after_rst_tag", bus.rs_tag, 1);
        @(negedge clk);
        set_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
